// File: rtl/debounce_pkg.sv
// Shared defaults and width helpers for the multi-channel switch debouncer.
package debounce_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 500000;
  localparam int DEFAULT_SYNC_STAGES   = 2;

  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles);
  endfunction

  // Holds 0..long_cycles so the counter can saturate one past the firing point.
  function automatic int hold_width(input int long_cycles);
    if (long_cycles > 0) begin
      return $clog2(long_cycles + 1);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, stable counter, edge pulses and optional long-press pulse.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   LONG_CYCLES   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_pulse
);

  localparam int            CW      = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt_r, cnt_next_s;
  logic                   level_r, level_next_s;
  logic                   rise_r, rise_next_s;
  logic                   fall_r, fall_next_s;
  logic                   sync_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Stable-count filter: any sample matching the current level restarts the count.
  always_comb begin
    cnt_next_s   = cnt_r;
    level_next_s = level_r;
    rise_next_s  = 1'b0;
    fall_next_s  = 1'b0;
    if (sync_s == level_r) begin
      cnt_next_s = '0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_next_s   = '0;
      level_next_s = sync_s;
      rise_next_s  = sync_s;
      fall_next_s  = ~sync_s;
    end else begin
      cnt_next_s = cnt_r + CW'(1);
    end
  end

  // Synchroniser, counter and level/edge registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r  <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_r   <= '0;
      level_r <= RESET_LEVEL;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], din};
      cnt_r   <= cnt_next_s;
      level_r <= level_next_s;
      rise_r  <= rise_next_s;
      fall_r  <= fall_next_s;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

  if (LONG_CYCLES > 0) begin : g_long
    localparam int            HW        = hold_width(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_r, hold_next_s;
    logic          long_r, long_next_s;

    // Hold counter stays at zero while low, so a fresh press always starts from 0.
    always_comb begin
      hold_next_s = hold_r;
      long_next_s = 1'b0;
      if (!level_r) begin
        hold_next_s = '0;
      end else if (hold_r == HOLD_FIRE) begin
        hold_next_s = HOLD_SAT;
        long_next_s = 1'b1;
      end else if (hold_r < HOLD_FIRE) begin
        hold_next_s = hold_r + HW'(1);
      end else begin
        hold_next_s = hold_r;
      end
    end

    // Long-press registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_r <= '0;
        long_r <= 1'b0;
      end else begin
        hold_r <= hold_next_s;
        long_r <= long_next_s;
      end
    end

    assign long_pulse = long_r;
  end else begin : g_no_long
    assign long_pulse = 1'b0;
  end

endmodule

// File: rtl/debouncer_bank.sv
// Bank of independent debounced switch inputs with level, edge and long-press outputs.
module debouncer_bank
  import debounce_pkg::*;
#(
  parameter int   CHANNELS      = 5,
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   LONG_CYCLES   = 0
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic [CHANNELS-1:0] i_Data,
  output logic [CHANNELS-1:0] o_Data,
  output logic [CHANNELS-1:0] o_Rise,
  output logic [CHANNELS-1:0] o_Fall,
  output logic [CHANNELS-1:0] o_Long
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("debouncer_bank: CHANNELS must be >= 1");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debouncer_bank: STABLE_CYCLES must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debouncer_bank: SYNC_STAGES must be >= 2");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES),
      .RESET_LEVEL   (RESET_LEVEL),
      .LONG_CYCLES   (LONG_CYCLES)
    ) u_channel (
      .clk        (i_CLK),
      .rst        (i_RST),
      .din        (i_Data[i]),
      .level      (o_Data[i]),
      .rise       (o_Rise[i]),
      .fall       (o_Fall[i]),
      .long_pulse (o_Long[i])
    );
  end

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed self-checking bench for debouncer_bank (2 channels, short counts).
module tb_debouncer_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] din;
  logic [1:0] o_data, o_rise, o_fall, o_long;
  logic [7:0] outs;
  int         tests = 0;
  int         fails = 0;

  // Packed view: {data, rise, fall, long}, two bits each (ch1, ch0).
  assign outs = {o_data, o_rise, o_fall, o_long};

  always #5 clk = ~clk;

  debouncer_bank #(
    .CHANNELS      (2),
    .STABLE_CYCLES (4),
    .SYNC_STAGES   (2),
    .RESET_LEVEL   (1'b0),
    .LONG_CYCLES   (10)
  ) dut (
    .i_CLK  (clk),
    .i_RST  (rst),
    .i_Data (din),
    .o_Data (o_data),
    .o_Rise (o_rise),
    .o_Fall (o_fall),
    .o_Long (o_long)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance n edges, expecting the same output vector after each.
  task automatic expect_for(input string tag, input int n, input logic [7:0] exp);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, outs, exp);
    end
  endtask

  localparam logic [7:0] ZERO   = 8'b00_00_00_00;
  localparam logic [7:0] L0     = 8'b01_00_00_00;
  localparam logic [7:0] L0_R   = 8'b01_01_00_00;
  localparam logic [7:0] L0_LG  = 8'b01_00_00_01;
  localparam logic [7:0] F0     = 8'b00_00_01_00;
  localparam logic [7:0] L11    = 8'b11_00_00_00;
  localparam logic [7:0] L11_R  = 8'b11_11_00_00;
  localparam logic [7:0] F11    = 8'b00_00_11_00;

  initial begin
    logic [11:0] pat;
    pat = 12'b0000_0111_0111;
    rst = 1'b1;
    din = 2'b00;

    // Reset state
    expect_for("reset", 3, ZERO);
    rst = 1'b0;
    expect_for("idle", 2, ZERO);

    // Press ch0: level after edge 6, rise for exactly one cycle
    din = 2'b01;
    expect_for("press_wait", 5, ZERO);
    expect_for("press_rise", 1, L0_R);
    // Held: long fires 10 edges after the rise edge, once only
    expect_for("hold_wait", 9, L0);
    expect_for("long_fire", 1, L0_LG);
    expect_for("long_norepeat", 6, L0);
    // Release: fall 6 edges later
    din = 2'b00;
    expect_for("rel_wait", 5, L0);
    expect_for("rel_fall", 1, F0);
    expect_for("rel_idle", 2, ZERO);

    // Bounce shorter than the stable count never reaches the output
    for (int i = 0; i < 12; i++) begin
      din = {1'b0, pat[i]};
      tick();
      chk("bounce", outs, ZERO);
    end
    expect_for("bounce_tail", 4, ZERO);

    // Short press: level falls 7 edges after the rise edge, no long pulse
    din = 2'b01;
    expect_for("short_wait", 5, ZERO);
    expect_for("short_rise", 1, L0_R);
    expect_for("short_hold", 1, L0);
    din = 2'b00;
    expect_for("short_hold2", 5, L0);
    expect_for("short_fall", 1, F0);
    expect_for("short_nolong", 12, ZERO);
    // Re-press: hold restarts from zero
    din = 2'b01;
    expect_for("repress_wait", 5, ZERO);
    expect_for("repress_rise", 1, L0_R);
    expect_for("repress_hold", 9, L0);
    expect_for("repress_long", 1, L0_LG);
    din = 2'b00;
    expect_for("repress_rel", 5, L0);
    expect_for("repress_fall", 1, F0);
    expect_for("repress_idle", 2, ZERO);

    // Both channels on the same edge
    din = 2'b11;
    expect_for("both_wait", 5, ZERO);
    expect_for("both_rise", 1, L11_R);
    din = 2'b00;
    expect_for("both_hold", 5, L11);
    expect_for("both_fall", 1, F11);
    expect_for("both_idle", 2, ZERO);

    // Reset mid-count (cnt = 2 after the fourth edge)
    din = 2'b01;
    expect_for("midcnt_wait", 4, ZERO);
    rst = 1'b1;
    expect_for("midcnt_rst", 2, ZERO);
    rst = 1'b0;
    // Input held high across reset: normal latency afterwards
    expect_for("postrst_wait", 5, ZERO);
    expect_for("postrst_rise", 1, L0_R);
    expect_for("midhold_wait", 5, L0);
    // Reset with level high and hold = 5
    rst = 1'b1;
    expect_for("midhold_rst", 3, ZERO);
    rst = 1'b0;
    expect_for("rst2_wait", 5, ZERO);
    expect_for("rst2_rise", 1, L0_R);
    expect_for("rst2_hold", 9, L0);
    expect_for("rst2_long", 1, L0_LG);
    expect_for("rst2_after", 3, L0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
